// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit sides.
//   - default bit timing and word length
//   - 3-bit receive FSM state encoding
package uart_pkg;

  // 50 MHz system clock, 115200 baud
  localparam int UART_CLKS_PER_BIT = 434;
  localparam int UART_DATA_BITS    = 8;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_START      = 3'd1;
  localparam logic [2:0] ST_DATA       = 3'd2;
  localparam logic [2:0] ST_STOP       = 3'd3;
  localparam logic [2:0] ST_BREAK_WAIT = 3'd4;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    START      = ST_START,
    DATA       = ST_DATA,
    STOP       = ST_STOP,
    BREAK_WAIT = ST_BREAK_WAIT
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous serial line.
// Both flops reset to 1 so the line reads as idle out of reset.
//   Clk   in  system clock
//   Reset in  asynchronous active-low reset
//   Rx    in  raw serial line
//   Rx_s  out synchronised line (2-clock latency)
module uart_rx_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic Rx,
  output logic Rx_s
);

  logic rx_meta;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rx_meta <= 1'b1;
      Rx_s    <= 1'b1;
    end else begin
      rx_meta <= Rx;
      Rx_s    <= rx_meta;
    end
  end

endmodule

// File: rtl/uart_rx_controller.sv
// uart_rx_controller: receive-side sequencer. Synchronises Rx, validates the
// start bit at its midpoint, strobes the external shift register once per data
// bit at mid-bit, checks the stop bit and raises done / sticky status flags.
//   Clk         in  system clock
//   Reset       in  asynchronous active-low reset
//   Rx          in  raw serial line, idle high
//   Clear_Flag  in  clears Rx_Flag and Frame_Error (a simultaneous set wins)
//   Sample_Bit  out synchronised line value -> shift register serial input
//   Shift_En    out one-cycle shift strobe  -> shift register enable
//   Rx_Done     out one-cycle pulse after a frame with a valid stop bit
//   Rx_Flag     out sticky word-available
//   Frame_Error out sticky stop-bit-was-0
//   Busy        out FSM not idle
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Rx,
  input  logic Clear_Flag,
  output logic Sample_Bit,
  output logic Shift_En,
  output logic Rx_Done,
  output logic Rx_Flag,
  output logic Frame_Error,
  output logic Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic             rx_s;
  rx_state_e        state, state_nxt;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic             shift, done_set, err_set;

  uart_rx_sync u_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .Rx    (Rx),
    .Rx_s  (rx_s)
  );

  assign Sample_Bit = rx_s;
  assign Shift_En   = shift;
  assign Busy       = (state != IDLE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    shift       = 1'b0;
    done_set    = 1'b0;
    err_set     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt   = START;
          clk_cnt_nxt = '0;
        end
      end
      START: begin
        clk_cnt_nxt = clk_cnt + 1'b1;
        // Re-check the line at the start-bit midpoint; high means a glitch.
        if (clk_cnt == CNT_HALF) begin
          clk_cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        clk_cnt_nxt = clk_cnt + 1'b1;
        // Counting restarted at the start midpoint, so this lands mid-bit.
        if (clk_cnt == CNT_LAST) begin
          shift       = 1'b1;
          clk_cnt_nxt = '0;
          if (bit_cnt == BIT_LAST) state_nxt = STOP;
          else                     bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      STOP: begin
        clk_cnt_nxt = clk_cnt + 1'b1;
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt = '0;
          if (rx_s) begin
            done_set  = 1'b1;
            state_nxt = IDLE;
          end else begin
            err_set   = 1'b1;
            state_nxt = BREAK_WAIT;
          end
        end
      end
      BREAK_WAIT: begin
        // A held-low line must return high before another start is accepted.
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Rx_Done     <= 1'b0;
      Rx_Flag     <= 1'b0;
      Frame_Error <= 1'b0;
    end else begin
      Rx_Done <= done_set;
      if (done_set)        Rx_Flag <= 1'b1;
      else if (Clear_Flag) Rx_Flag <= 1'b0;
      if (err_set)         Frame_Error <= 1'b1;
      else if (Clear_Flag) Frame_Error <= 1'b0;
    end
  end

endmodule
